// File: rtl/solar_scan_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | solar_scan_if                                                           |
// | Bundles the enable/clear controls, the shared-ADC handshake and the     |
// | published light-sensor readings of the solar tracker sequencer.         |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
interface solar_scan_if;
    logic        en;
    logic        err_clr;
    logic        adc_done;
    logic [15:0] adc_data;
    logic [1:0]  adc_sel;
    logic        adc_start;
    logic [15:0] lsn;
    logic [15:0] lse;
    logic [15:0] lss;
    logic [15:0] lsw;
    logic        valid;
    logic        busy;
    logic        err;

    modport master (
        input  en, err_clr, adc_done, adc_data,
        output adc_sel, adc_start, lsn, lse, lss, lsw, valid, busy, err
    );

    modport slave (
        output en, err_clr, adc_done, adc_data,
        input  adc_sel, adc_start, lsn, lse, lss, lsw, valid, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/solar_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | solar_scan                                                              |
// | Periodic four-channel sweep of one shared ADC with settle delay,        |
// | conversion timeout and coherent publication of the four readings.       |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module solar_scan #(
    parameter int PERIOD  = 1000,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 64
) (
    input  wire          clk,
    input  wire          rst,
    solar_scan_if.master bus
);

    localparam logic [15:0] c_PERIOD_M1 = 16'(PERIOD - 1);
    localparam logic [7:0]  c_SETTLE    = 8'(SETTLE);
    localparam logic [7:0]  c_SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [7:0]  c_TIMEOUT   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_run;
    logic [15:0] r_pcnt;
    logic        w_tick;
    logic [7:0]  r_scnt;
    logic [7:0]  w_scnt_nx;
    logic [7:0]  r_wcnt;
    logic [7:0]  w_wcnt_nx;
    logic [1:0]  r_sel;
    logic [1:0]  w_sel_nx;
    logic        r_start;
    logic        w_start_nx;
    logic        w_chan_go;
    logic        w_conv_go;
    logic        w_cap;
    logic        w_publish;
    logic        w_timeout;
    logic        r_busy;
    logic        r_valid;
    logic        r_err;
    logic [15:0] r_shadow [4];
    logic [15:0] r_lsn;
    logic [15:0] r_lse;
    logic [15:0] r_lss;
    logic [15:0] r_lsw;

    // r_run holds the counter at 0 for the first enabled edge, so the first
    // tick lands PERIOD cycles after that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run  <= 1'b0;
            r_pcnt <= 16'd0;
        end else begin
            r_run <= bus.en;
            if (!bus.en || !r_run || (r_pcnt == c_PERIOD_M1)) begin
                r_pcnt <= 16'd0;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end
        end
    end

    assign w_tick = bus.en && (r_pcnt == c_PERIOD_M1);

    always_comb begin
        w_state_nx = r_state;
        w_scnt_nx  = r_scnt;
        w_wcnt_nx  = r_wcnt;
        w_sel_nx   = r_sel;
        w_start_nx = 1'b0;
        w_chan_go  = 1'b0;
        w_conv_go  = 1'b0;
        w_cap      = 1'b0;
        w_publish  = 1'b0;
        w_timeout  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_sel_nx  = 2'd0;
                    w_chan_go = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_scnt == 8'd0) begin
                    w_conv_go = 1'b1;
                end else begin
                    w_scnt_nx = r_scnt - 8'd1;
                end
            end
            S_CONVERT: begin
                // r_wcnt == 0 is the start cycle, where a done is ignored.
                if ((r_wcnt != 8'd0) && bus.adc_done) begin
                    w_cap = 1'b1;
                    if (r_sel == 2'd3) begin
                        w_state_nx = S_PUBLISH;
                        w_publish  = 1'b1;
                    end else begin
                        w_sel_nx  = r_sel + 2'd1;
                        w_chan_go = 1'b1;
                    end
                end else if (r_wcnt == c_TIMEOUT) begin
                    w_timeout  = 1'b1;
                    w_state_nx = S_IDLE;
                    w_sel_nx   = 2'd0;
                end else begin
                    w_wcnt_nx = r_wcnt + 8'd1;
                end
            end
            S_PUBLISH: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_chan_go) begin
            if (c_SETTLE == 8'd0) begin
                w_conv_go = 1'b1;
            end else begin
                w_state_nx = S_SETTLE;
                w_scnt_nx  = c_SETTLE_M1;
            end
        end

        if (w_conv_go) begin
            w_state_nx = S_CONVERT;
            w_start_nx = 1'b1;
            w_wcnt_nx  = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_scnt  <= 8'd0;
            r_wcnt  <= 8'd0;
            r_sel   <= 2'd0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_scnt  <= w_scnt_nx;
            r_wcnt  <= w_wcnt_nx;
            r_sel   <= w_sel_nx;
            r_start <= w_start_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_valid <= w_publish;
            r_err   <= w_timeout | (r_err & ~bus.err_clr);
        end
    end

    // The west reading bypasses its shadow so all four outputs and valid
    // appear together in the PUBLISH cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 16'd0;
            end
            r_lsn <= 16'd0;
            r_lse <= 16'd0;
            r_lss <= 16'd0;
            r_lsw <= 16'd0;
        end else begin
            if (w_cap) begin
                r_shadow[r_sel] <= bus.adc_data;
            end
            if (w_publish) begin
                r_lsn <= r_shadow[0];
                r_lse <= r_shadow[1];
                r_lss <= r_shadow[2];
                r_lsw <= bus.adc_data;
            end
        end
    end

    assign bus.adc_sel   = r_sel;
    assign bus.adc_start = r_start;
    assign bus.lsn       = r_lsn;
    assign bus.lse       = r_lse;
    assign bus.lss       = r_lss;
    assign bus.lsw       = r_lsw;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_solar_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_solar_scan                                                           |
// | Directed bench: two sequencers (PERIOD 100 and 20) share one ADC model. |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_solar_scan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    solar_scan_if bus_a();
    solar_scan_if bus_b();

    solar_scan #(.PERIOD(100), .SETTLE(2), .TIMEOUT(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    solar_scan #(.PERIOD(20), .SETTLE(2), .TIMEOUT(8)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int         checks   = 0;
    int         errors   = 0;
    bit         model_on = 1'b0;
    int         a_sil    = -1;
    int         b_sil    = -1;
    int         a_cnt    = 0;
    int         b_cnt    = 0;
    logic [1:0] a_lsel   = 2'd0;
    logic [1:0] b_lsel   = 2'd0;
    logic [63:0] exp_set = 64'h1000_1111_1222_1333;

    // ADC model: done exactly 3 cycles after each start unless that sel is silenced;
    // random noise on the handshake while the model is off.
    initial begin
        forever begin
            @(negedge clk);
            if (!model_on) begin
                bus_a.adc_done = 1'($urandom);
                bus_a.adc_data = 16'($urandom);
                bus_b.adc_done = 1'($urandom);
                bus_b.adc_data = 16'($urandom);
                a_cnt = 0;
                b_cnt = 0;
            end else begin
                bus_a.adc_done = 1'b0;
                bus_b.adc_done = 1'b0;
                if (a_cnt > 0) begin
                    a_cnt--;
                    if (a_cnt == 0) begin
                        bus_a.adc_done = 1'b1;
                        bus_a.adc_data = 16'h1000 + 16'h0111 * {14'd0, a_lsel};
                    end
                end
                if (b_cnt > 0) begin
                    b_cnt--;
                    if (b_cnt == 0) begin
                        bus_b.adc_done = 1'b1;
                        bus_b.adc_data = 16'h1000 + 16'h0111 * {14'd0, b_lsel};
                    end
                end
                if (bus_a.adc_start && (int'(bus_a.adc_sel) != a_sil)) begin
                    a_cnt  = 3;
                    a_lsel = bus_a.adc_sel;
                end
                if (bus_b.adc_start && (int'(bus_b.adc_sel) != b_sil)) begin
                    b_cnt  = 3;
                    b_lsel = bus_b.adc_sel;
                end
            end
        end
    end

    task automatic wait_start_a(input int bound, input int want, output int n);
        bit found = 1'b0;
        n = 0;
        while (!found && n < bound) begin
            @(negedge clk);
            n++;
            if (bus_a.adc_start && (want < 0 || int'(bus_a.adc_sel) == want)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_start: no start for sel %0d within %0d cycles", want, bound);
        end
    endtask

    task automatic wait_valid_a(input int bound, output int n);
        bit found = 1'b0;
        n = 0;
        while (!found && n < bound) begin
            @(negedge clk);
            n++;
            if (bus_a.valid) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no valid within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus_a.en = 1'($urandom);
            bus_a.err_clr = 1'($urandom);
            bus_b.en = 1'($urandom);
            bus_b.err_clr = 1'($urandom);
            #1;
            checks++;
            if ({bus_a.adc_sel, bus_a.adc_start, bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw,
                 bus_a.valid, bus_a.busy, bus_a.err} !== 70'd0) begin
                errors++;
                $display("FAIL reset_a: outputs got %h required 0", {bus_a.adc_sel, bus_a.adc_start,
                         bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw, bus_a.valid, bus_a.busy, bus_a.err});
            end
            checks++;
            if ({bus_b.adc_sel, bus_b.adc_start, bus_b.valid, bus_b.busy, bus_b.err} !== 6'd0) begin
                errors++;
                $display("FAIL reset_b: ctrl outputs got %b required 0",
                         {bus_b.adc_sel, bus_b.adc_start, bus_b.valid, bus_b.busy, bus_b.err});
            end
        end
        @(negedge clk);
        bus_a.en = 1'b0; bus_a.err_clr = 1'b0;
        bus_b.en = 1'b0; bus_b.err_clr = 1'b0;
        model_on = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus_a.en = 1'b1;
        wait_start_a(300, -1, n);
        checks++;
        if (n !== 103) begin
            errors++;
            $display("FAIL first_start_latency: got %0d required 103", n);
        end
        checks++;
        if (bus_a.adc_sel !== 2'd0 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start_state: sel/busy got %0d/%b required 0/1", bus_a.adc_sel, bus_a.busy);
        end
    endtask

    // Entered in the cycle of the first start of a sweep.
    task automatic test_sweep();
        int st = 1;
        int vcnt = 0;
        int v_rel = -1;
        bit stale_ok = 1'b1;
        for (int r = 1; r <= 30; r++) begin
            @(negedge clk);
            if (bus_a.adc_start) begin
                checks++;
                if (r !== 6 * st || bus_a.adc_sel !== 2'(st)) begin
                    errors++;
                    $display("FAIL sweep_start: cycle/sel got %0d/%0d required %0d/%0d", r, bus_a.adc_sel, 6 * st, st);
                end
                st++;
            end
            if (bus_a.valid) begin
                vcnt++;
                if (v_rel < 0) v_rel = r;
                checks++;
                if ({bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw} !== exp_set) begin
                    errors++;
                    $display("FAIL sweep_data: got %h required %h", {bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw}, exp_set);
                end
            end
            if (v_rel < 0 && {bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw} !== 64'd0) stale_ok = 1'b0;
            if (r == 23) begin
                checks++;
                if (bus_a.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_busy_drop: got %b required 0", bus_a.busy);
                end
            end
        end
        checks++;
        if (st !== 4) begin
            errors++;
            $display("FAIL sweep_start_count: got %0d required 4", st);
        end
        checks++;
        if (vcnt !== 1 || v_rel !== 22) begin
            errors++;
            $display("FAIL sweep_valid: count/cycle got %0d/%0d required 1/22", vcnt, v_rel);
        end
        checks++;
        if (!stale_ok) begin
            errors++;
            $display("FAIL sweep_early_publish: got changed outputs before valid required unchanged");
        end
    endtask

    task automatic test_timeout();
        int n;
        int vcnt = 0;
        a_sil = 2;
        wait_start_a(300, 2, n);
        for (int r = 1; r <= 8; r++) begin
            @(negedge clk);
            if (bus_a.valid) vcnt++;
        end
        checks++;
        if (bus_a.err !== 1'b0 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err/busy got %b/%b required 0/1", bus_a.err, bus_a.busy);
        end
        @(negedge clk);
        if (bus_a.valid) vcnt++;
        checks++;
        if (bus_a.err !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.adc_sel !== 2'd0 || vcnt !== 0) begin
            errors++;
            $display("FAIL timeout_abort: err/busy/sel/valids got %b/%b/%0d/%0d required 1/0/0/0",
                     bus_a.err, bus_a.busy, bus_a.adc_sel, vcnt);
        end
        checks++;
        if ({bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw} !== exp_set) begin
            errors++;
            $display("FAIL timeout_hold: got %h required %h", {bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw}, exp_set);
        end
        a_sil = -1;
        wait_start_a(300, -1, n);
        checks++;
        if (bus_a.adc_sel !== 2'd0 || bus_a.err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover: sel/err got %0d/%b required 0/1", bus_a.adc_sel, bus_a.err);
        end
        wait_valid_a(100, n);
        checks++;
        if ({bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw} !== exp_set) begin
            errors++;
            $display("FAIL recover_data: got %h required %h", {bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw}, exp_set);
        end
        @(negedge clk);
        bus_a.err_clr = 1'b1;
        @(negedge clk);
        bus_a.err_clr = 1'b0;
        checks++;
        if (bus_a.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b required 0", bus_a.err);
        end
        a_sil = 2;
        wait_start_a(300, 2, n);
        repeat (8) @(negedge clk);
        bus_a.err_clr = 1'b1;
        @(negedge clk);
        bus_a.err_clr = 1'b0;
        checks++;
        if (bus_a.err !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins: got %b required 1", bus_a.err);
        end
        a_sil = -1;
        bus_a.err_clr = 1'b1;
        @(negedge clk);
        bus_a.err_clr = 1'b0;
    endtask

    task automatic test_dropped_tick();
        int starts[$];
        int vcnt = 0;
        int v_at = -1;
        @(negedge clk);
        bus_b.en = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (bus_b.adc_start) starts.push_back(n);
            if (bus_b.valid && n <= 62) begin
                vcnt++;
                v_at = n;
            end
            if (n == 63) begin
                checks++;
                if (bus_b.adc_start !== 1'b1 || bus_b.adc_sel !== 2'd0) begin
                    errors++;
                    $display("FAIL drop_next_sweep: start/sel at 63 got %b/%0d required 1/0", bus_b.adc_start, bus_b.adc_sel);
                end
            end
        end
        bus_b.en = 1'b0;
        checks++;
        if (starts.size() !== 6 || starts[0] !== 23 || starts[3] !== 41 || starts[4] !== 63) begin
            errors++;
            $display("FAIL drop_starts: count/first/fourth got %0d/%0d/%0d required 6/23/41",
                     starts.size(), (starts.size() > 0) ? starts[0] : -1, (starts.size() > 3) ? starts[3] : -1);
        end
        checks++;
        if (vcnt !== 1 || v_at !== 45) begin
            errors++;
            $display("FAIL drop_valid: count/cycle got %0d/%0d required 1/45", vcnt, v_at);
        end
    endtask

    task automatic test_en_drop();
        int n;
        int st_before = 0;
        int st_after = 0;
        int vcnt = 0;
        int v_rel = -1;
        wait_start_a(300, 1, n);
        bus_a.en = 1'b0;
        for (int r = 1; r <= 300; r++) begin
            @(negedge clk);
            if (bus_a.adc_start) begin
                if (vcnt == 0) st_before++;
                else st_after++;
            end
            if (bus_a.valid) begin
                vcnt++;
                if (v_rel < 0) v_rel = r;
            end
        end
        checks++;
        if (vcnt !== 1 || v_rel !== 16) begin
            errors++;
            $display("FAIL en_drop_valid: count/cycle got %0d/%0d required 1/16", vcnt, v_rel);
        end
        checks++;
        if (st_before !== 2 || st_after !== 0) begin
            errors++;
            $display("FAIL en_drop_starts: before/after got %0d/%0d required 2/0", st_before, st_after);
        end
    endtask

    task automatic test_async_reset();
        int n;
        bit quiet = 1'b1;
        bus_a.en = 1'b1;
        wait_start_a(300, -1, n);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_a.busy, bus_a.adc_start, bus_a.valid, bus_a.adc_sel, bus_a.err} !== 6'd0 ||
            {bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw} !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: busy/start/data got %b/%b/%h required 0/0/0",
                     bus_a.busy, bus_a.adc_start, {bus_a.lsn, bus_a.lse, bus_a.lss, bus_a.lsw});
        end
        bus_a.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            if (bus_a.busy || bus_a.adc_start || bus_a.valid || bus_a.lsn !== 16'd0 || bus_a.lsw !== 16'd0)
                quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL late_done: got activity after reset required idle");
        end
    endtask

    initial begin
        bus_a.en = 1'b0; bus_a.err_clr = 1'b0;
        bus_b.en = 1'b0; bus_b.err_clr = 1'b0;
        test_reset();
        test_sweep();
        test_timeout();
        test_dropped_tick();
        test_en_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
